// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the WB/MD stages, the decode hazard logic and the
// register file write port.
interface regfile_wb_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_ready;

    logic          md_valid;
    logic [AW-1:0] md_addr;
    logic [DW-1:0] md_data;
    logic          md_ready;

    logic          sb_set;
    logic [AW-1:0] sb_set_addr;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          hazard;
    logic          sb_err;

    logic          rf_regwrite;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_writedata;

    // Pipeline side: drives requests and read addresses.
    modport master (
        output wb_valid, wb_addr, wb_data,
        output md_valid, md_addr, md_data,
        output sb_set, sb_set_addr, rs, rt,
        input  wb_ready, md_ready, hazard, sb_err,
        input  rf_regwrite, rf_rd, rf_writedata
    );

    // Arbiter side.
    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  md_valid, md_addr, md_data,
        input  sb_set, sb_set_addr, rs, rt,
        output wb_ready, md_ready, hazard, sb_err,
        output rf_regwrite, rf_rd, rf_writedata
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between the writeback stage (WB) and the
// multiply/divide unit (MD), with a pending-destination scoreboard that
// drives the decode-stage hazard.
//
// state  | meaning
// -------+-----------------------------------------------------------
// PRI_WB | WB wins contested cycles; counting consecutive WB wins
// PRI_MD | WB has won STARVE_MAX contested cycles in a row; MD wins
module regfile_wb_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int NREG = 2**AW;
    localparam int CW   = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_TC = CW'(STARVE_MAX);

    typedef enum logic {PRI_WB, PRI_MD} pri_t;

    pri_t            state, state_nxt;
    logic [CW-1:0]   starve_cnt, starve_cnt_nxt;
    logic            contested;
    logic            wb_xfer;
    logic            md_xfer;

    logic [NREG-1:0] pending, pending_nxt;
    logic            sb_set_ok;
    logic            sb_err_q, sb_err_nxt;

    logic            rf_regwrite_q;
    logic [AW-1:0]   rf_rd_q;
    logic [DW-1:0]   rf_writedata_q;

    // Grants depend on the valids and priority only; held off during reset.
    always_comb begin
        contested = bus.wb_valid & bus.md_valid;
        wb_xfer   = rst_n & bus.wb_valid & (~bus.md_valid | (state == PRI_WB));
        md_xfer   = rst_n & bus.md_valid & (~bus.wb_valid | (state == PRI_MD));
    end

    assign bus.wb_ready = wb_xfer;
    assign bus.md_ready = md_xfer;

    // Priority state and starvation counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PRI_WB;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Next priority: MD activity ending (transfer or idle) resets fairness.
    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        if (md_xfer || !bus.md_valid) begin
            starve_cnt_nxt = '0;
            state_nxt      = PRI_WB;
        end else if (contested && wb_xfer) begin
            if (starve_cnt != STARVE_TC)
                starve_cnt_nxt = starve_cnt + 1'b1;
            if (starve_cnt_nxt == STARVE_TC)
                state_nxt = PRI_MD;
        end
    end

    // Registered write port; r0 writes are accepted but never enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_regwrite_q  <= 1'b0;
            rf_rd_q        <= '0;
            rf_writedata_q <= '0;
        end else if (wb_xfer) begin
            rf_regwrite_q  <= (bus.wb_addr != '0);
            rf_rd_q        <= bus.wb_addr;
            rf_writedata_q <= bus.wb_data;
        end else if (md_xfer) begin
            rf_regwrite_q  <= (bus.md_addr != '0);
            rf_rd_q        <= bus.md_addr;
            rf_writedata_q <= bus.md_data;
        end else begin
            rf_regwrite_q  <= 1'b0;
        end
    end

    assign bus.rf_regwrite  = rf_regwrite_q;
    assign bus.rf_rd        = rf_rd_q;
    assign bus.rf_writedata = rf_writedata_q;

    // Scoreboard update: a new issue overrides a same-cycle MD completion.
    always_comb begin
        sb_set_ok   = bus.sb_set & (bus.sb_set_addr != '0);
        pending_nxt = pending;
        if (md_xfer)
            pending_nxt[bus.md_addr] = 1'b0;
        if (sb_set_ok)
            pending_nxt[bus.sb_set_addr] = 1'b1;
        pending_nxt[0] = 1'b0;
        sb_err_nxt = sb_set_ok & pending[bus.sb_set_addr];
    end

    // Scoreboard and double-issue error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            sb_err_q <= 1'b0;
        end else begin
            pending  <= pending_nxt;
            sb_err_q <= sb_err_nxt;
        end
    end

    assign bus.sb_err = sb_err_q;

    // Stall decode while a source is pending or its write is still in flight.
    always_comb begin
        bus.hazard = 1'b0;
        if (bus.rs != '0 &&
            (pending[bus.rs] || (rf_regwrite_q && rf_rd_q == bus.rs)))
            bus.hazard = 1'b1;
        if (bus.rt != '0 &&
            (pending[bus.rt] || (rf_regwrite_q && rf_rd_q == bus.rt)))
            bus.hazard = 1'b1;
    end

endmodule
